// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared types and constants for the memory-stage controller:
//   - state_t      : controller FSM states (IDLE / BUSY / HALTED)
//   - RSRC_*       : writeback source-select encodings carried on reg_src
//   - DEF_MAX_WAIT : default ack timeout in BUSY cycles
// ---------------------------------------------------------------------------
package mem_stage_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Writeback result select (decoded downstream in WB, passed through here)
   localparam logic [2:0] RSRC_ALU = 3'd0;
   localparam logic [2:0] RSRC_MEM = 3'd1;
   localparam logic [2:0] RSRC_PC2 = 3'd2;
   localparam logic [2:0] RSRC_IMM = 3'd3;

   localparam int DEF_MAX_WAIT = 15;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl_if
// Data-memory req/ack bus between the memory-stage controller (master) and
// a multi-cycle data memory (slave).
//   dmem_req   : access request, held until the ack cycle
//   dmem_wr    : 1 = store, 0 = load
//   dmem_addr  : byte address, stable while dmem_req=1
//   dmem_wdata : store data, stable while dmem_req=1
//   dmem_ack   : one-cycle completion pulse from memory
//   dmem_rdata : load data, valid in the ack cycle
// ---------------------------------------------------------------------------
interface mem_stage_ctrl_if;

   logic        dmem_req;
   logic        dmem_wr;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_ack;
   logic [15:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_wr, dmem_addr, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_wr, dmem_addr, dmem_wdata,
      output dmem_ack, dmem_rdata
   );

endinterface

// File: rtl/mem_stage_ctrl_wb_latch.sv
// ---------------------------------------------------------------------------
// dff_16bit
// 16-bit register with async active-low reset and load enable.
//   clk_i, rst_n_i : clock, async active-low reset (clears to 0)
//   en_i           : load d_i on the rising edge when high
//   d_i / q_o      : data in / registered data out
//
// mem_wb_latch
// MEM/WB result register bank. All wb_* data fields load together when the
// controller raises its capture strobe; they hold otherwise.
//   clk_i, rst_n_i      : clock, async active-low reset
//   en_i                : capture strobe from the controller FSM
//   rdata_i..reg_we_i   : next values for the wb fields
//   rdata_o..reg_we_o   : registered wb fields
// ---------------------------------------------------------------------------
module dff_16bit (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic [15:0] d_i,
   output logic [15:0] q_o
);

   logic [15:0] q_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)  q_q <= '0;
      else if (en_i) q_q <= d_i;
   end

   assign q_o = q_q;

endmodule

module mem_wb_latch (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic [15:0] rdata_i,
   input  logic [15:0] alu_i,
   input  logic [15:0] pc2_i,
   input  logic [1:0]  reg_dst_i,
   input  logic [2:0]  reg_src_i,
   input  logic        reg_we_i,
   output logic [15:0] rdata_o,
   output logic [15:0] alu_o,
   output logic [15:0] pc2_o,
   output logic [1:0]  reg_dst_o,
   output logic [2:0]  reg_src_o,
   output logic        reg_we_o
);

   logic [5:0] ctl_q;

   dff_16bit u_rdata (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .d_i(rdata_i), .q_o(rdata_o));
   dff_16bit u_alu   (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .d_i(alu_i),   .q_o(alu_o));
   dff_16bit u_pc2   (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .d_i(pc2_i),   .q_o(pc2_o));

   // The narrow WB control fields share one small register
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)  ctl_q <= '0;
      else if (en_i) ctl_q <= {reg_dst_i, reg_src_i, reg_we_i};
   end

   assign reg_dst_o = ctl_q[5:4];
   assign reg_src_o = ctl_q[3:1];
   assign reg_we_o  = ctl_q[0];

endmodule

// File: rtl/mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// mem_stage_ctrl
// Memory-stage controller between the EX/MEM register and writeback.
// Non-memory instructions pass to the MEM/WB outputs with one cycle of
// latency. Loads/stores are issued on the dmem req/ack bus; the front of the
// pipeline is stalled until the ack cycle, in which stall drops so upstream
// advances on the same edge the result is captured. An ack timeout, an
// incoming halt, or (optionally) a misaligned access parks the block in
// HALTED until reset.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject accesses whose byte
// address is odd (err + halt instead of a request). Without it odd addresses
// are forwarded to dmem_addr unchanged.
//
// Ports:
//   clk, rst                 : clock, async active-low reset
//   in_valid                 : EX/MEM holds a live instruction
//   alu_in, wdata_in, pc2_in : ALU result/address, store data, PC+2
//   mem_en_in, mem_wr_in     : memory access / store select
//   halt_in                  : halt (dump) request
//   reg_dst_in/src_in/we_in  : WB controls, passed through
//   dmem                     : data-memory bus (master side)
//   stall                    : freeze PC, IF/ID, ID/EX, EX/MEM
//   wb_*                     : registered MEM/WB outputs
//   halt_out, err            : sticky halt and memory-error flags
// ---------------------------------------------------------------------------
module mem_stage_ctrl
   import mem_stage_pkg::*;
#(
   parameter int MAX_WAIT = DEF_MAX_WAIT,
   parameter int CNT_W    = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic [15:0]             alu_in,
   input  logic [15:0]             wdata_in,
   input  logic [15:0]             pc2_in,
   input  logic                    mem_en_in,
   input  logic                    mem_wr_in,
   input  logic                    halt_in,
   input  logic [1:0]              reg_dst_in,
   input  logic [2:0]              reg_src_in,
   input  logic                    reg_we_in,
   mem_stage_ctrl_if.master        dmem,
   output logic                    stall,
   output logic                    wb_valid,
   output logic [15:0]             wb_rdata,
   output logic [15:0]             wb_alu,
   output logic [15:0]             wb_pc2,
   output logic [1:0]              wb_reg_dst,
   output logic [2:0]              wb_reg_src,
   output logic                    wb_reg_we,
   output logic                    halt_out,
   output logic                    err
);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             req_q, wr_q, wb_valid_q, halt_q, err_q;
   logic [15:0]      addr_q, wdata_q, pc2_q;
   logic [1:0]       reg_dst_q;
   logic [2:0]       reg_src_q;
   logic             reg_we_q;

   logic             align_fault;
   logic             timeout;
   logic             wb_cap;
   logic [15:0]      wb_rdata_d, wb_alu_d, wb_pc2_d;
   logic [1:0]       wb_reg_dst_d;
   logic [2:0]       wb_reg_src_d;
   logic             wb_reg_we_d;

`ifdef MEM_ALIGN_CHECK_EN
   assign align_fault = alu_in[0];
`else
   assign align_fault = 1'b0;
`endif

   assign timeout = (cnt_q == CNT_W'(MAX_WAIT)) && !dmem.dmem_ack;

   // Capture strobe: a plain pass-through in IDLE, or the ack cycle in BUSY
   always_comb begin
      wb_cap = 1'b0;
      case (state_q)
         ST_IDLE: wb_cap = in_valid && !halt_in && !mem_en_in;
         ST_BUSY: wb_cap = dmem.dmem_ack;
         default: wb_cap = 1'b0;
      endcase
   end

   // In BUSY the result comes from the fields captured at request time;
   // stores write back zero rather than whatever is on the read bus
   always_comb begin
      wb_rdata_d   = '0;
      wb_alu_d     = alu_in;
      wb_pc2_d     = pc2_in;
      wb_reg_dst_d = reg_dst_in;
      wb_reg_src_d = reg_src_in;
      wb_reg_we_d  = reg_we_in;
      if (state_q == ST_BUSY) begin
         wb_rdata_d   = wr_q ? 16'h0000 : dmem.dmem_rdata;
         wb_alu_d     = addr_q;
         wb_pc2_d     = pc2_q;
         wb_reg_dst_d = reg_dst_q;
         wb_reg_src_d = reg_src_q;
         wb_reg_we_d  = reg_we_q;
      end
   end

   // stall rises combinationally on a memory op in IDLE and drops in the
   // ack cycle so upstream advances on the capture edge
   always_comb begin
      stall = 1'b0;
      case (state_q)
         ST_IDLE:   stall = in_valid && mem_en_in;
         ST_BUSY:   stall = !dmem.dmem_ack;
         ST_HALTED: stall = 1'b1;
         default:   stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         wr_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         pc2_q      <= '0;
         reg_dst_q  <= '0;
         reg_src_q  <= '0;
         reg_we_q   <= 1'b0;
         wb_valid_q <= 1'b0;
         halt_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               wb_valid_q <= 1'b0;
               if (in_valid) begin
                  if (halt_in) begin
                     halt_q  <= 1'b1;
                     state_q <= ST_HALTED;
                  end else if (mem_en_in && align_fault) begin
                     err_q   <= 1'b1;
                     halt_q  <= 1'b1;
                     state_q <= ST_HALTED;
                  end else if (mem_en_in) begin
                     req_q     <= 1'b1;
                     wr_q      <= mem_wr_in;
                     addr_q    <= alu_in;
                     wdata_q   <= wdata_in;
                     pc2_q     <= pc2_in;
                     reg_dst_q <= reg_dst_in;
                     reg_src_q <= reg_src_in;
                     reg_we_q  <= reg_we_in;
                     cnt_q     <= '0;
                     state_q   <= ST_BUSY;
                  end else begin
                     wb_valid_q <= 1'b1;
                  end
               end
            end
            ST_BUSY: begin
               // Saturating wait counter
               if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
               if (dmem.dmem_ack) begin
                  req_q      <= 1'b0;
                  wb_valid_q <= 1'b1;
                  state_q    <= ST_IDLE;
               end else if (timeout) begin
                  req_q      <= 1'b0;
                  err_q      <= 1'b1;
                  halt_q     <= 1'b1;
                  wb_valid_q <= 1'b0;
                  state_q    <= ST_HALTED;
               end
            end
            ST_HALTED: begin
               req_q      <= 1'b0;
               wb_valid_q <= 1'b0;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   mem_wb_latch u_wb_latch (
      .clk_i     (clk),
      .rst_n_i   (rst),
      .en_i      (wb_cap),
      .rdata_i   (wb_rdata_d),
      .alu_i     (wb_alu_d),
      .pc2_i     (wb_pc2_d),
      .reg_dst_i (wb_reg_dst_d),
      .reg_src_i (wb_reg_src_d),
      .reg_we_i  (wb_reg_we_d),
      .rdata_o   (wb_rdata),
      .alu_o     (wb_alu),
      .pc2_o     (wb_pc2),
      .reg_dst_o (wb_reg_dst),
      .reg_src_o (wb_reg_src),
      .reg_we_o  (wb_reg_we)
   );

   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_wr    = wr_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign wb_valid        = wb_valid_q;
   assign halt_out        = halt_q;
   assign err             = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl. Expected writeback results are queued
// when an instruction is driven and popped by a monitor whenever wb_valid is
// seen; control/bus outputs are checked inline. Honours MEM_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_mem_stage_ctrl;
   import mem_stage_pkg::*;

   localparam int MW = 15;

   typedef struct packed {
      logic [15:0] rdata;
      logic [15:0] alu;
      logic [15:0] pc2;
      logic [1:0]  dst;
      logic [2:0]  src;
      logic        we;
   } wb_exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, mem_en_in, mem_wr_in, halt_in, reg_we_in;
   logic [15:0] alu_in, wdata_in, pc2_in;
   logic [1:0]  reg_dst_in;
   logic [2:0]  reg_src_in;
   logic        stall, wb_valid, wb_reg_we, halt_out, err;
   logic [15:0] wb_rdata, wb_alu, wb_pc2;
   logic [1:0]  wb_reg_dst;
   logic [2:0]  wb_reg_src;

   int n_cmp = 0;
   int n_bad = 0;
   wb_exp_t sb[$];

   mem_stage_ctrl_if dmem_if ();

   mem_stage_ctrl #(.MAX_WAIT(MW), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .alu_in(alu_in),
      .wdata_in(wdata_in), .pc2_in(pc2_in), .mem_en_in(mem_en_in),
      .mem_wr_in(mem_wr_in), .halt_in(halt_in), .reg_dst_in(reg_dst_in),
      .reg_src_in(reg_src_in), .reg_we_in(reg_we_in), .dmem(dmem_if.master),
      .stall(stall), .wb_valid(wb_valid), .wb_rdata(wb_rdata), .wb_alu(wb_alu),
      .wb_pc2(wb_pc2), .wb_reg_dst(wb_reg_dst), .wb_reg_src(wb_reg_src),
      .wb_reg_we(wb_reg_we), .halt_out(halt_out), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic men, input logic mwr, input logic hlt,
                        input logic [15:0] alu, input logic [15:0] wd, input logic [15:0] pc2,
                        input logic [1:0] dst, input logic [2:0] src, input logic we);
      in_valid = v; mem_en_in = men; mem_wr_in = mwr; halt_in = hlt;
      alu_in = alu; wdata_in = wd; pc2_in = pc2;
      reg_dst_in = dst; reg_src_in = src; reg_we_in = we;
   endtask

   task automatic drive_idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2'd0, 3'd0, 1'b0);
   endtask

   task automatic push(input logic [15:0] rd, input logic [15:0] alu, input logic [15:0] pc2,
                       input logic [1:0] dst, input logic [2:0] src, input logic we);
      wb_exp_t e;
      e.rdata = rd; e.alu = alu; e.pc2 = pc2; e.dst = dst; e.src = src; e.we = we;
      sb.push_back(e);
   endtask

   task automatic drained(input string tag);
      #2;
      chk(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic rst_pulse();
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
   endtask

   // Writeback monitor: every wb_valid cycle must match the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b1 && wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("wb_unexpected", 32'(wb_valid), 32'd0);
         end else begin
            wb_exp_t e;
            e = sb.pop_front();
            chk("wb_rdata",   32'(wb_rdata),   32'(e.rdata));
            chk("wb_alu",     32'(wb_alu),     32'(e.alu));
            chk("wb_pc2",     32'(wb_pc2),     32'(e.pc2));
            chk("wb_reg_dst", 32'(wb_reg_dst), 32'(e.dst));
            chk("wb_reg_src", 32'(wb_reg_src), 32'(e.src));
            chk("wb_reg_we",  32'(wb_reg_we),  32'(e.we));
         end
      end
   end

   initial begin
      int nst;
      int nreq;
      rst = 1'b0;
      drive_idle();
      dmem_if.dmem_ack = 1'b0;
      dmem_if.dmem_rdata = 16'h0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_req",      32'(dmem_if.dmem_req), 32'd0);
      chk("rst_stall",    32'(stall), 32'd0);
      chk("rst_halt",     32'(halt_out), 32'd0);
      chk("rst_err",      32'(err), 32'd0);
      chk("rst_wb_alu",   32'(wb_alu), 32'd0);
      @(posedge clk); #1 rst = 1'b1;

      // ALU pass-through
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0, 16'h0102, 2'd1, RSRC_ALU, 1'b1);
      push(16'h0, 16'h1234, 16'h0102, 2'd1, RSRC_ALU, 1'b1);
      @(negedge clk); chk("alu_stall", 32'(stall), 32'd0);
      tick(); drive_idle();
      @(negedge clk); chk("alu_stall2", 32'(stall), 32'd0);
      drained("alu_drained");

      // Load 0x0040, 3 wait cycles, rdata 0xBEEF
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h5555, 16'h0200, 2'd2, RSRC_MEM, 1'b1);
      push(16'hBEEF, 16'h0040, 16'h0200, 2'd2, RSRC_MEM, 1'b1);
      nst = 0;
      @(negedge clk); chk("ld_stall_idle", 32'(stall), 32'd1); nst += int'(stall);
      tick();
      @(negedge clk);
      chk("ld_req",  32'(dmem_if.dmem_req), 32'd1);
      chk("ld_wr",   32'(dmem_if.dmem_wr), 32'd0);
      chk("ld_addr", 32'(dmem_if.dmem_addr), 32'h0040);
      nst += int'(stall);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("ld_addr_hold", 32'(dmem_if.dmem_addr), 32'h0040);
         nst += int'(stall);
      end
      tick(); dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 16'hBEEF;
      @(negedge clk); chk("ld_ack_stall", 32'(stall), 32'd0); nst += int'(stall);
      tick(); dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 16'h0; drive_idle();
      @(negedge clk);
      chk("ld_req_drop", 32'(dmem_if.dmem_req), 32'd0);
      chk("ld_stall_cycles", 32'(nst), 32'd5);
      drained("ld_drained");

      // Store 0x0010 <- 0xA5A5, 1 wait cycle; read bus noise must not leak
      tick();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0010, 16'hA5A5, 16'h0300, 2'd0, RSRC_ALU, 1'b0);
      push(16'h0, 16'h0010, 16'h0300, 2'd0, RSRC_ALU, 1'b0);
      @(negedge clk); chk("st_stall_idle", 32'(stall), 32'd1);
      tick();
      @(negedge clk);
      chk("st_req",   32'(dmem_if.dmem_req), 32'd1);
      chk("st_wr",    32'(dmem_if.dmem_wr), 32'd1);
      chk("st_addr",  32'(dmem_if.dmem_addr), 32'h0010);
      chk("st_wdata", 32'(dmem_if.dmem_wdata), 32'hA5A5);
      tick();
      @(negedge clk);
      chk("st_addr_hold",  32'(dmem_if.dmem_addr), 32'h0010);
      chk("st_wdata_hold", 32'(dmem_if.dmem_wdata), 32'hA5A5);
      tick(); dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 16'hFFFF;
      @(negedge clk); chk("st_ack_stall", 32'(stall), 32'd0);
      tick(); dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 16'h0; drive_idle();
      @(negedge clk); chk("st_req_drop", 32'(dmem_if.dmem_req), 32'd0);
      drained("st_drained");

      // Stray ack in IDLE is ignored
      tick(); dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 16'h1111;
      @(negedge clk);
      chk("stray_req",   32'(dmem_if.dmem_req), 32'd0);
      chk("stray_stall", 32'(stall), 32'd0);
      tick(); dmem_if.dmem_ack = 1'b0;
      @(negedge clk); chk("stray_wb_valid", 32'(wb_valid), 32'd0);

      // Reset while BUSY, then a late ack after release
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0044, 16'h0, 16'h0600, 2'd1, RSRC_MEM, 1'b1);
      tick();
      @(negedge clk); chk("rb_req", 32'(dmem_if.dmem_req), 32'd1);
      drive_idle();
      #1 rst = 1'b0;
      #1;
      chk("rb_req0",    32'(dmem_if.dmem_req), 32'd0);
      chk("rb_addr0",   32'(dmem_if.dmem_addr), 32'd0);
      chk("rb_wb_alu0", 32'(wb_alu), 32'd0);
      chk("rb_wb_pc20", 32'(wb_pc2), 32'd0);
      chk("rb_stall0",  32'(stall), 32'd0);
      chk("rb_wbv0",    32'(wb_valid), 32'd0);
      @(posedge clk); #1 rst = 1'b1;
      dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 16'hDEAD;
      @(negedge clk); chk("rb_late_req", 32'(dmem_if.dmem_req), 32'd0);
      tick(); dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 16'h0;
      @(negedge clk);
      chk("rb_late_wbv", 32'(wb_valid), 32'd0);
      chk("rb_late_err", 32'(err), 32'd0);

      // Second ALU op confirms a clean IDLE after reset
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h5678, 16'h0, 16'h0400, 2'd3, RSRC_PC2, 1'b1);
      push(16'h0, 16'h5678, 16'h0400, 2'd3, RSRC_PC2, 1'b1);
      @(negedge clk); chk("alu2_stall", 32'(stall), 32'd0);
      tick(); drive_idle();
      @(negedge clk);
      drained("alu2_drained");

      // Odd address load
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0041, 16'h0, 16'h0500, 2'd1, RSRC_MEM, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
      @(negedge clk);
      tick(); drive_idle();
      @(negedge clk);
      chk("al_req",   32'(dmem_if.dmem_req), 32'd0);
      chk("al_err",   32'(err), 32'd1);
      chk("al_halt",  32'(halt_out), 32'd1);
      chk("al_stall", 32'(stall), 32'd1);
`else
      push(16'h7E57, 16'h0041, 16'h0500, 2'd1, RSRC_MEM, 1'b1);
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("al_req",  32'(dmem_if.dmem_req), 32'd1);
      chk("al_addr", 32'(dmem_if.dmem_addr), 32'h0041);
      tick(); dmem_if.dmem_ack = 1'b1; dmem_if.dmem_rdata = 16'h7E57;
      @(negedge clk);
      tick(); dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = 16'h0; drive_idle();
      @(negedge clk);
      chk("al_err", 32'(err), 32'd0);
      drained("al_drained");
`endif
      rst_pulse();
      @(negedge clk);
      chk("al_rst_err", 32'(err), 32'd0);

      // Halt with mem_en: halt wins, no request
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0060, 16'h0, 16'h0700, 2'd0, RSRC_MEM, 1'b1);
      @(negedge clk);
      tick(); drive_idle();
      @(negedge clk);
      chk("hl_req",   32'(dmem_if.dmem_req), 32'd0);
      chk("hl_halt",  32'(halt_out), 32'd1);
      chk("hl_err",   32'(err), 32'd0);
      chk("hl_stall", 32'(stall), 32'd1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h9999, 16'h0, 16'h0800, 2'd1, RSRC_ALU, 1'b1);
      tick(); drive_idle();
      @(negedge clk);
      chk("hl_ignore_wbv", 32'(wb_valid), 32'd0);
      rst_pulse();

      // Ack timeout
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 16'h0, 16'h0900, 2'd2, RSRC_MEM, 1'b1);
      tick();
      nreq = 0;
      while (dmem_if.dmem_req === 1'b1 && nreq < 40) begin
         nreq++;
         tick();
      end
      chk("to_req_cycles", 32'(nreq), 32'(MW + 1));
      @(negedge clk);
      chk("to_err",   32'(err), 32'd1);
      chk("to_halt",  32'(halt_out), 32'd1);
      chk("to_req",   32'(dmem_if.dmem_req), 32'd0);
      chk("to_stall", 32'(stall), 32'd1);
      tick();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h4321, 16'h0, 16'h0A00, 2'd1, RSRC_ALU, 1'b1);
      tick(); drive_idle();
      @(negedge clk);
      chk("to_ignore_wbv",   32'(wb_valid), 32'd0);
      chk("to_stall_hold",   32'(stall), 32'd1);

      drained("final_drained");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
